// File: rtl/mem_access_unit.sv
// mem_access_unit: serialises fetch/load/store requests onto a single-port,
// variable-latency memory, with a watchdog that sets a sticky bus error.
`default_nettype none

module mem_access_unit #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Value of the counter during the last BUSY cycle the watchdog allows.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  state_t           state;
  state_t           next_state;
  kind_t            kind;
  logic [CNT_W-1:0] cnt;
  logic             any_req;
  logic             timeout_hit;

  assign any_req     = fetch_req | load_req | store_req;
  assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && !mem_ack && (cnt == CNT_LAST);
  assign stall       = !reset && (((state == IDLE) && any_req) || (state == BUSY));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = BUSY;
      BUSY:    if (mem_ack || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      kind      <= K_FETCH;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instr     <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state   <= next_state;
      mem_req <= (next_state == BUSY);
      done    <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt       <= '0;
            mem_wdata <= wdata;
            // Lower-priority requests are dropped, not queued.
            if (fetch_req) begin
              kind     <= K_FETCH;
              mem_addr <= pc_addr;
              mem_we   <= 1'b0;
            end else if (load_req) begin
              kind     <= K_LOAD;
              mem_addr <= data_addr;
              mem_we   <= 1'b0;
            end else begin
              kind     <= K_STORE;
              mem_addr <= data_addr;
              mem_we   <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_ack) begin
            if (kind == K_FETCH) instr <= mem_rdata;
            if (kind == K_LOAD)  rdata <= mem_rdata;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit (DATA_W=8, ADDR_W=8, TIMEOUT=15).
`default_nettype none

module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_req, load_req, store_req;
  logic [7:0] pc_addr, data_addr, wdata;
  logic       stall, done, bus_err, mem_req, mem_we, mem_ack;
  logic [7:0] instr, rdata, mem_addr, mem_wdata, mem_rdata;

  int nchk = 0;
  int nerr = 0;
  logic berr_exp = 1'b0;

  mem_access_unit #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
    .pc_addr(pc_addr), .data_addr(data_addr), .wdata(wdata),
    .stall(stall), .done(done), .instr(instr), .rdata(rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;       // {fetch, load, store}
    logic [7:0] pc;
    logic [7:0] daddr;
    logic [7:0] wd;
    int         ack_cyc;   // BUSY cycle in which ack is driven
    logic [7:0] mrd;
    logic [7:0] e_addr;
    logic       e_we;
    logic [7:0] e_instr;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next cycle; outputs are sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    fetch_req = 0; load_req = 0; store_req = 0;
    mem_ack = 0; mem_rdata = 8'h00;
  endtask

  task automatic run_vec(input vec_t v);
    {fetch_req, load_req, store_req} = v.req;
    pc_addr = v.pc; data_addr = v.daddr; wdata = v.wd;
    #1;
    chk("req_stall", stall, 1);
    for (int c = 1; c <= v.ack_cyc; c++) begin
      step();
      chk("busy_req", mem_req, 1);
      chk("busy_addr", mem_addr, v.e_addr);
      chk("busy_we", mem_we, v.e_we);
      if (v.e_we) chk("busy_wdata", mem_wdata, v.wd);
      chk("busy_stall", stall, 1);
      chk("busy_done", done, 0);
      if (c == v.ack_cyc) begin
        mem_ack = 1; mem_rdata = v.mrd;
      end
    end
    step();
    mem_ack = 0; mem_rdata = 8'h00;
    #1;
    chk("done_pulse", done, 1);
    chk("done_stall", stall, 0);
    chk("done_req", mem_req, 0);
    chk("done_instr", instr, v.e_instr);
    chk("done_rdata", rdata, v.e_rdata);
    chk("done_berr", bus_err, berr_exp);
    fetch_req = 0; load_req = 0; store_req = 0;
    step();
    chk("idle_done", done, 0);
    chk("idle_stall", stall, 0);
  endtask

  initial begin
    vecs[0] = '{3'b100, 8'h12, 8'h00, 8'h00, 1, 8'hA5, 8'h12, 1'b0, 8'hA5, 8'h00};
    vecs[1] = '{3'b001, 8'h00, 8'h40, 8'h3C, 3, 8'h77, 8'h40, 1'b1, 8'hA5, 8'h00};
    vecs[2] = '{3'b110, 8'h05, 8'h80, 8'h00, 1, 8'h5A, 8'h05, 1'b0, 8'h5A, 8'h00};
    vecs[3] = '{3'b010, 8'h00, 8'h33, 8'h00, 2, 8'hC3, 8'h33, 1'b0, 8'h5A, 8'hC3};
    vecs[4] = '{3'b011, 8'h00, 8'h77, 8'h11, 1, 8'h99, 8'h77, 1'b0, 8'h5A, 8'h99};

    clear_inputs();
    pc_addr = 0; data_addr = 0; wdata = 0;
    reset = 1;
    fetch_req = 1;
    step(); step();
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_instr", instr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_berr", bus_err, 0);
    fetch_req = 0;
    reset = 0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Stray ack in IDLE must be ignored.
    mem_ack = 1; mem_rdata = 8'hFF;
    step();
    mem_ack = 0;
    step();
    chk("stray_instr", instr, 8'h5A);
    chk("stray_rdata", rdata, 8'h99);
    chk("stray_req", mem_req, 0);
    chk("stray_done", done, 0);

    // Back-to-back: fetch held through DONE is re-accepted after one IDLE cycle.
    fetch_req = 1; pc_addr = 8'h44;
    step();
    mem_ack = 1; mem_rdata = 8'h66;
    step();
    mem_ack = 0;
    chk("b2b_done1", done, 1);
    chk("b2b_instr1", instr, 8'h66);
    step();
    #1;
    chk("b2b_gap_req", mem_req, 0);
    chk("b2b_gap_stall", stall, 1);
    step();
    chk("b2b_req2", mem_req, 1);
    chk("b2b_addr2", mem_addr, 8'h44);
    mem_ack = 1; mem_rdata = 8'h67;
    step();
    mem_ack = 0; fetch_req = 0;
    chk("b2b_done2", done, 1);
    chk("b2b_instr2", instr, 8'h67);
    step();

    // Watchdog: no ack, mem_req high for exactly 15 cycles.
    fetch_req = 1; pc_addr = 8'h20;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk("to_req", mem_req, 1);
      chk("to_berr_early", bus_err, 0);
      chk("to_done_early", done, 0);
    end
    step();
    chk("to_done", done, 1);
    chk("to_berr", bus_err, 1);
    chk("to_req_low", mem_req, 0);
    chk("to_instr", instr, 8'h67);
    fetch_req = 0;
    step();
    berr_exp = 1'b1;
    begin
      vec_t v;
      v = '{3'b100, 8'h21, 8'h00, 8'h00, 1, 8'h42, 8'h21, 1'b0, 8'h42, 8'h99};
      run_vec(v);
    end

    // Reset in cycle 2 of a load; the ack in cycle 3 must be ignored.
    load_req = 1; data_addr = 8'h90;
    step();
    chk("rm_req1", mem_req, 1);
    step();
    reset = 1;
    #1;
    chk("rm_stall", stall, 0);
    step();
    reset = 0; load_req = 0;
    mem_ack = 1; mem_rdata = 8'hEE;
    chk("rm_req3", mem_req, 0);
    chk("rm_rdata3", rdata, 0);
    chk("rm_berr", bus_err, 0);
    step();
    mem_ack = 0;
    chk("rm_done4", done, 0);
    chk("rm_rdata4", rdata, 0);
    chk("rm_instr4", instr, 0);
    chk("rm_req4", mem_req, 0);
    step();
    chk("rm_done5", done, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Sequences all memory traffic of the multicycle CPU onto a single-port, variable-latency memory. It sits directly downstream of the control unit: it turns the control unit's instruction-fetch, load and store requests into a registered memory handshake. It holds the fetched instruction word and the loaded data word for the datapath, and raises `stall` to freeze the control unit's state machine until the access completes. A watchdog bounds every access and flags a sticky bus error.

## Interface
Parameters:
- `DATA_W`, 8, width of instruction/data words and memory data bus
- `ADDR_W`, 8, memory address width
- `TIMEOUT`, 15, max cycles in BUSY without `mem_ack`; 0 disables the watchdog

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge
- `fetch_req`  in  1  instruction fetch request; held by control unit while `stall`=1
- `load_req`  in  1  data load request
- `store_req`  in  1  data store request
- `pc_addr`  in  ADDR_W  fetch address
- `data_addr`  in  ADDR_W  load/store address
- `wdata`  in  DATA_W  store data
- `stall`  out  1  control unit must not advance
- `done`  out  1  one-cycle completion pulse
- `instr`  out  DATA_W  last fetched instruction word
- `rdata`  out  DATA_W  last loaded data word
- `bus_err`  out  1  sticky watchdog error
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1 = write, registered
- `mem_addr`  out  ADDR_W  registered
- `mem_wdata`  out  DATA_W  registered
- `mem_rdata`  in  DATA_W  valid when `mem_ack`=1
- `mem_ack`  in  1  single-cycle completion from memory

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: `any_req` = fetch|load|store. If set, latch the request kind and `mem_addr`/`mem_we`/`mem_wdata`, then go to BUSY.
  - Priority: fetch > load > store. Lower-priority requests are dropped, not queued.
  - Fetch uses `pc_addr`, we=0. Load uses `data_addr`, we=0. Store uses `data_addr`, `wdata`, we=1.
- BUSY: `mem_req`=1, with address, we and wdata held stable. Watchdog counter increments every cycle.
  - `mem_ack`=1: fetch → `instr`←`mem_rdata`; load → `rdata`←`mem_rdata`; store → no capture. Go to DONE.
  - Counter reaches `TIMEOUT` with no ack (TIMEOUT≠0): set `bus_err`, leave `instr`/`rdata` unchanged, go to DONE.
  - If ack and timeout occur in the same cycle, the ack wins and `bus_err` is not set.
- DONE: `done`=1, `stall`=0, `mem_req`=0. All requests are ignored this cycle. Next state is IDLE.
- `stall` (combinational) = (IDLE & `any_req`) | BUSY.
- `mem_ack` outside BUSY is ignored.
- The watchdog counter clears on entry to BUSY. Its width is sized to hold `TIMEOUT`.
- `bus_err` clears only on `reset`.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `instr`=0, `rdata`=0, `done`=0, `bus_err`=0, state IDLE, counter 0.
  - `stall`=0 while in reset; the combinational term is masked by `reset`.
- Request seen in cycle 0 → `mem_req` high from cycle 1. Ack in cycle k → DONE in cycle k+1, with `instr`/`rdata` valid from cycle k+1.
- Zero-wait memory (ack in cycle 1): `done` in cycle 2, giving 2 stall cycles per access.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then `done`=1 and `bus_err`=1 in the following cycle.
- Reset mid-access: at the reset edge, all registers clear. `mem_req` is low from the next cycle, and the in-flight ack is ignored.
- Back-to-back: a request held through DONE is accepted in the following IDLE cycle, so `mem_req` is low for at least one cycle between accesses.

## Test plan
- Fetch, ack 0 wait: `pc_addr`=0x12, `mem_rdata`=0xA5 with `mem_ack` in cycle 1 → `mem_addr`=0x12, `mem_we`=0; cycle 2 `done`=1, `stall`=0, `instr`=0xA5; `rdata` stays 0.
- Store, ack after 3 cycles: `data_addr`=0x40, `wdata`=0x3C → `mem_we`=1, `mem_wdata`=0x3C held cycles 1–3; `done` in cycle 4; `instr`/`rdata` unchanged.
- Simultaneous fetch+load: `pc_addr`=0x05, `data_addr`=0x80 → `mem_addr`=0x05 only; `instr` captures `mem_rdata`, no load is issued.
- Timeout: TIMEOUT=15, no ack → `mem_req` high cycles 1–15, cycle 16 `done`=1 and `bus_err`=1. A subsequent ack-ed fetch completes normally and `bus_err` stays 1.
- Reset mid-access: assert `reset` in cycle 2 of a load, then drive `mem_ack` in cycle 3 → `mem_req`=0 from cycle 3, `rdata`=0, `done` never pulses.
- Stray ack in IDLE with `mem_rdata`=0xFF → no change to `instr`/`rdata`/state.
